// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - USB bus typedefs and packing FIFO defaults
package usb_pkg;

  typedef logic [7:0]  bus8_t;
  typedef logic [31:0] bus32_t;

  localparam int USB_FIFO_DEPTH_DEF = 16;

  typedef struct packed {
    bus32_t     data;
    logic [2:0] nbytes;
    logic       last;
  } usb_word_t;

endpackage

// File: rtl/usb_byte_packer.sv
// rtl/usb_byte_packer.sv - byte lane accumulator feeding the packing FIFO
module usb_byte_packer
  import usb_pkg::*;
#(
  parameter  int WORD_BYTES = 4,
  localparam int IW         = $clog2(WORD_BYTES),
  localparam int NW         = IW + 1,
  localparam int DW         = 8 * WORD_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          valid_i,
  input  bus8_t         data_i,
  input  logic          last_i,
  output logic          push_o,
  output logic [DW-1:0] word_o,
  output logic [NW-1:0] nbytes_o,
  output logic          last_o
);

  logic [DW-1:0] lanes_q, lanes_d;
  logic [IW-1:0] idx_q, idx_d;

  // Lanes are zeroed on every push, so unfilled lanes of a short word read as 0.
  always_comb begin
    word_o                         = lanes_q;
    word_o[{idx_q, 3'b000} +: 8]   = data_i;
    push_o   = valid_i && ((idx_q == IW'(WORD_BYTES - 1)) || last_i);
    nbytes_o = NW'(idx_q) + NW'(1);
    last_o   = last_i;

    lanes_d = lanes_q;
    idx_d   = idx_q;
    if (clr_i) begin
      lanes_d = '0;
      idx_d   = '0;
    end else if (valid_i) begin
      if (push_o) begin
        lanes_d = '0;
        idx_d   = '0;
      end else begin
        lanes_d = word_o;
        idx_d   = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q <= '0;
      idx_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/usb_pack_fifo.sv
// rtl/usb_pack_fifo.sv - byte-to-word packing FIFO; USB_PACK_FIFO_PKTCNT_EN selects store-and-forward
module usb_pack_fifo
  import usb_pkg::*;
#(
  parameter  int DEPTH      = USB_FIFO_DEPTH_DEF,
  parameter  int WORD_BYTES = 4,
  localparam int AW         = $clog2(DEPTH),
  localparam int NW         = $clog2(WORD_BYTES) + 1,
  localparam int DW         = 8 * WORD_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_valid,
  input  bus8_t         wr_data,
  input  logic          wr_last,
  output logic          wr_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [NW-1:0] rd_nbytes,
  output logic          rd_last,
  input  logic          rd_ready,
  output logic [AW:0]   level
`ifdef USB_PACK_FIFO_PKTCNT_EN
  ,
  output logic [AW:0]   pkt_cnt
`endif
);

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_d;
  logic          ready_q;
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [NW-1:0] nb_mem_q   [DEPTH];
  logic          last_mem_q [DEPTH];

  logic          flush, accept, pop, empty, full_now;
  logic          push;
  logic [DW-1:0] push_word;
  logic [NW-1:0] push_nbytes;
  logic          push_last;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full_now = (level == (AW+1)'(DEPTH));
  assign wr_ready = ready_q;
  assign accept   = wr_valid && ready_q && !flush;
  assign pop      = rd_valid && rd_ready && !flush;

  assign rd_data   = data_mem_q[rd_ptr_q[AW-1:0]];
  assign rd_nbytes = nb_mem_q[rd_ptr_q[AW-1:0]];
  assign rd_last   = last_mem_q[rd_ptr_q[AW-1:0]];

`ifdef USB_PACK_FIFO_PKTCNT_EN
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;

  // Storage full with no complete packet can never drain: flush it.
  assign flush    = clr || (full_now && (pkt_cnt_q == '0));
  assign rd_valid = !empty && (pkt_cnt_q != '0);
  assign pkt_cnt  = pkt_cnt_q;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (flush) begin
      pkt_cnt_d = '0;
    end else begin
      if (push && push_last)
        pkt_cnt_d = pkt_cnt_d + (AW+1)'(1);
      if (pop && rd_last)
        pkt_cnt_d = pkt_cnt_d - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_cnt_q <= '0;
    else     pkt_cnt_q <= pkt_cnt_d;
  end
`else
  assign flush    = clr;
  assign rd_valid = !empty;
`endif

  usb_byte_packer #(.WORD_BYTES(WORD_BYTES)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (flush),
    .valid_i  (accept),
    .data_i   (wr_data),
    .last_i   (wr_last),
    .push_o   (push),
    .word_o   (push_word),
    .nbytes_o (push_nbytes),
    .last_o   (push_last)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    level_d = wr_ptr_d - rd_ptr_d;
  end

  // ready is registered from next-state occupancy so it is low throughout reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= (level_d != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        nb_mem_q[i]   <= '0;
        last_mem_q[i] <= 1'b0;
      end
    end else if (push && !flush) begin
      data_mem_q[wr_ptr_q[AW-1:0]] <= push_word;
      nb_mem_q[wr_ptr_q[AW-1:0]]   <= push_nbytes;
      last_mem_q[wr_ptr_q[AW-1:0]] <= push_last;
    end
  end

endmodule

// File: tb/tb_usb_pack_fifo.sv
// tb/tb_usb_pack_fifo.sv - randomized and directed bench for usb_pack_fifo against a queue model
module tb_usb_pack_fifo;

  localparam int DEPTH = 16;
  localparam int WB    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_last = 1'b0;
  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [2:0]  rd_nbytes;
  logic        rd_last;
  logic        rd_ready = 1'b0;
  logic [4:0]  level;
`ifdef USB_PACK_FIFO_PKTCNT_EN
  logic [4:0]  pkt_cnt;
`endif

  usb_pack_fifo #(.DEPTH(DEPTH), .WORD_BYTES(WB)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_nbytes (rd_nbytes),
    .rd_last   (rd_last),
    .rd_ready  (rd_ready),
    .level     (level)
`ifdef USB_PACK_FIFO_PKTCNT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          n;
    bit          l;
  } word_t;

  word_t     mq[$];
  bit [7:0]  pend[$];
  bit        m_ready = 1'b0;
  int        total = 0;
  int        passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int npk();
    int c = 0;
    foreach (mq[i]) if (mq[i].l) c++;
    return c;
  endfunction

  function automatic bit m_valid();
`ifdef USB_PACK_FIFO_PKTCNT_EN
    return (mq.size() != 0) && (npk() != 0);
`else
    return mq.size() != 0;
`endif
  endfunction

  // One clock: drive at negedge, advance model at the edge, compare just after it.
  task automatic cycle(input bit wv, input bit [7:0] wd, input bit wl, input bit rr, input bit cl);
    bit flush, acc, pp;
    word_t w;
    @(negedge clk);
    wr_valid = wv; wr_data = wd; wr_last = wl; rd_ready = rr; clr = cl;
    flush = cl;
`ifdef USB_PACK_FIFO_PKTCNT_EN
    if (mq.size() == DEPTH && npk() == 0) flush = 1'b1;
`endif
    acc = wv && m_ready && !flush;
    pp  = m_valid() && rr && !flush;
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
      pend.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) begin
        pend.push_back(wd);
        if (pend.size() == WB || wl) begin
          w.d = '0;
          foreach (pend[i]) w.d[8*i +: 8] = pend[i];
          w.n = pend.size();
          w.l = wl;
          mq.push_back(w);
          pend.delete();
        end
      end
    end
    m_ready = (mq.size() < DEPTH);
    chk("level", 64'(level), 64'(mq.size()));
    chk("wr_ready", 64'(wr_ready), 64'(m_ready));
    chk("rd_valid", 64'(rd_valid), 64'(m_valid()));
`ifdef USB_PACK_FIFO_PKTCNT_EN
    chk("pkt_cnt", 64'(pkt_cnt), 64'(npk()));
`endif
    if (mq.size() != 0) begin
      chk("rd_data", 64'(rd_data), 64'(mq[0].d));
      chk("rd_nbytes", 64'(rd_nbytes), 64'(mq[0].n));
      chk("rd_last", 64'(rd_last), 64'(mq[0].l));
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (m_valid() && guard < 100) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    if (mq.size() != 0 || pend.size() != 0) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("drain_level", 64'(level), 64'd0);
  endtask

  initial begin
    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_nbytes", 64'(rd_nbytes), 64'd0);
    chk("rst_rd_last", 64'(rd_last), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("post_rst_level", 64'(level), 64'd0);
    m_ready = 1'b1;

    // 8 bytes 01..08, last on 08, nothing popped.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 8'(i), i == 8, 1'b0, 1'b0);
      if (i == 4) chk("seq8_level1", 64'(level), 64'd1);
    end
    chk("seq8_level2", 64'(level), 64'd2);
    chk("seq8_w0", 64'(rd_data), 64'h04030201);
    chk("seq8_w0_last", 64'(rd_last), 64'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("seq8_w1", 64'(rd_data), 64'h08070605);
    chk("seq8_w1_n", 64'(rd_nbytes), 64'd4);
    chk("seq8_w1_last", 64'(rd_last), 64'd1);
    drain();

    // 5 bytes A0..A4 -> one full word and a 1-byte tail.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA0 + 8'(i), i == 4, 1'b0, 1'b0);
    chk("seq5_w0", 64'(rd_data), 64'hA3A2A1A0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("seq5_w1", 64'(rd_data), 64'h000000A4);
    chk("seq5_w1_n", 64'(rd_nbytes), 64'd1);
    chk("seq5_w1_last", 64'(rd_last), 64'd1);
    drain();

`ifndef USB_PACK_FIFO_PKTCNT_EN
    // Fill to DEPTH, pop one, then stream push+pop at DEPTH-1.
    for (int i = 0; i < 64; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("full_level", 64'(level), 64'd16);
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("pop1_level", 64'(level), 64'd15);
    chk("pop1_wr_ready", 64'(wr_ready), 64'd1);
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 4; j++) cycle(1'b1, 8'($urandom), 1'b0, j == 3, 1'b0);
      chk("stream_level", 64'(level), 64'd15);
    end
    drain();
`else
    // Store-and-forward: words are held until their packet completes.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b1, 1'b0);
    chk("sf_hold_valid", 64'(rd_valid), 64'd0);
    cycle(1'b1, 8'h35, 1'b1, 1'b0, 1'b0);
    chk("sf_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("sf_valid", 64'(rd_valid), 64'd1);
    drain();
    begin
      int guard = 0;
      while (mq.size() < DEPTH && guard < 80) begin
        cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        guard++;
      end
    end
    chk("ovf_full", 64'(level), 64'd16);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("ovf_flush_level", 64'(level), 64'd0);
`endif

    // clr mid-packet discards packer; next packet starts at lane 0.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("clr_level", 64'(level), 64'd0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
    chk("clr_next_word", 64'(rd_data), 64'h44332211);
    drain();

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
